// File: rtl/traceback_unit.sv
// Traceback engine: walks the direction memory from an end cell back to the
// origin, emitting one alignment op (M/D/I) per valid/ready handshake.
module traceback_unit #(
    parameter int ROW_W = 10,
    parameter int COL_W = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [ROW_W-1:0]       i_row,
    input  logic [COL_W-1:0]       i_col,
    output logic                   o_mem_en,
    output logic [ROW_W-1:0]       o_mem_row,
    output logic [COL_W-1:0]       o_mem_col,
    input  logic [3:0]             i_mem_data,
    output logic [1:0]             o_op,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [ROW_W+COL_W:0]   o_len
);

    localparam int LEN_W = ROW_W + COL_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_EMIT, S_TAIL, S_DONE} state_t;
    typedef enum logic [1:0] {MAT_V, MAT_I, MAT_D} mat_t;
    typedef enum logic [1:0] {OP_M = 2'd0, OP_D = 2'd1, OP_I = 2'd2} op_t;

    state_t           state;
    mat_t             mat;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [3:0]       dir_r;

    op_t              step_op;
    mat_t             step_mat;
    logic [ROW_W-1:0] adv_row;
    logic [COL_W-1:0] adv_col;

    // dir = {d_dir, i_dir, v_dir[1:0]}; v_dir = 3 is illegal and decodes as M
    function automatic op_t pick_op(input logic [3:0] dir, input mat_t m);
        op_t op;
        case (m)
            MAT_D:   op = OP_D;
            MAT_I:   op = OP_I;
            default: begin
                case (dir[1:0])
                    2'd1:    op = OP_D;
                    2'd2:    op = OP_I;
                    default: op = OP_M;
                endcase
            end
        endcase
        return op;
    endfunction

    function automatic mat_t pick_mat(input logic [3:0] dir, input op_t op);
        mat_t m;
        case (op)
            OP_D:    m = dir[3] ? MAT_V : MAT_D;
            OP_I:    m = dir[2] ? MAT_V : MAT_I;
            default: m = MAT_V;
        endcase
        return m;
    endfunction

    // Coordinates after the op currently being offered (EMIT or TAIL)
    always_comb begin
        step_op  = pick_op(dir_r, mat);
        step_mat = pick_mat(dir_r, step_op);
        adv_row  = row;
        adv_col  = col;
        if (state == S_TAIL) begin
            if (row != '0) adv_row = row - ROW_W'(1);
            else           adv_col = col - COL_W'(1);
        end else begin
            if (step_op != OP_I) adv_row = row - ROW_W'(1);
            if (step_op != OP_D) adv_col = col - COL_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            mat       <= MAT_V;
            row       <= '0;
            col       <= '0;
            dir_r     <= '0;
            o_mem_en  <= 1'b0;
            o_mem_row <= '0;
            o_mem_col <= '0;
            o_op      <= '0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_len     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        row    <= i_row;
                        col    <= i_col;
                        mat    <= MAT_V;
                        o_len  <= '0;
                        o_busy <= 1'b1;
                        if (i_row == '0 && i_col == '0) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end else if (i_row == '0 || i_col == '0) begin
                            state   <= S_TAIL;
                            o_valid <= 1'b1;
                            o_op    <= (i_row != '0) ? OP_D : OP_I;
                        end else begin
                            state     <= S_RD;
                            o_mem_en  <= 1'b1;
                            o_mem_row <= i_row;
                            o_mem_col <= i_col;
                        end
                    end
                end
                S_RD: begin
                    o_mem_en <= 1'b0;
                    state    <= S_CAP;
                end
                // The op is decoded from the raw memory word here so that
                // o_op is already registered in the first EMIT cycle.
                S_CAP: begin
                    dir_r   <= i_mem_data;
                    o_op    <= pick_op(i_mem_data, mat);
                    o_valid <= 1'b1;
                    state   <= S_EMIT;
                end
                S_EMIT, S_TAIL: begin
                    if (i_ready) begin
                        row   <= adv_row;
                        col   <= adv_col;
                        o_len <= o_len + LEN_W'(1);
                        if (state == S_EMIT) mat <= step_mat;
                        // Reaching the origin skips an empty TAIL visit
                        if (adv_row == '0 && adv_col == '0) begin
                            state   <= S_DONE;
                            o_valid <= 1'b0;
                            o_done  <= 1'b1;
                        end else if (adv_row == '0 || adv_col == '0) begin
                            state   <= S_TAIL;
                            o_valid <= 1'b1;
                            o_op    <= (adv_row != '0) ? OP_D : OP_I;
                        end else begin
                            state     <= S_RD;
                            o_valid   <= 1'b0;
                            o_mem_en  <= 1'b1;
                            o_mem_row <= adv_row;
                            o_mem_col <= adv_col;
                        end
                    end
                end
                S_DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_traceback_unit.sv
// Self-checking bench for traceback_unit: directed and randomized tracebacks
// compared against a path-walking reference model of the direction matrix.
module tb_traceback_unit;

    localparam int ROW_W = 10;
    localparam int COL_W = 10;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n;
    logic                 i_start;
    logic [ROW_W-1:0]     i_row;
    logic [COL_W-1:0]     i_col;
    logic                 o_mem_en;
    logic [ROW_W-1:0]     o_mem_row;
    logic [COL_W-1:0]     o_mem_col;
    logic [3:0]           i_mem_data;
    logic [1:0]           o_op;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_busy;
    logic                 o_done;
    logic [ROW_W+COL_W:0] o_len;

    traceback_unit #(.ROW_W(ROW_W), .COL_W(COL_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_row(i_row), .i_col(i_col),
        .o_mem_en(o_mem_en), .o_mem_row(o_mem_row), .o_mem_col(o_mem_col),
        .i_mem_data(i_mem_data), .o_op(o_op), .o_valid(o_valid), .i_ready(i_ready),
        .o_busy(o_busy), .o_done(o_done), .o_len(o_len)
    );

    always #5 i_clk = ~i_clk;

    // Direction memory: data valid one cycle after a read, junk otherwise
    logic [3:0] mem [0:15][0:15];
    always @(posedge i_clk) begin
        if (o_mem_en && o_mem_row < 16 && o_mem_col < 16)
            i_mem_data <= mem[o_mem_row[3:0]][o_mem_col[3:0]];
        else
            i_mem_data <= 4'($urandom);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int exp_ops[$];
    int exp_rd[$];
    int exp_k, exp_n;
    int got_ops[$];
    int got_rd[$];

    // Ops: 0=M 1=D 2=I; matrices: 0=V 1=I 2=D
    task automatic model(input int r0, input int c0);
        int r, c, m, op, v;
        logic [3:0] d;
        r = r0; c = c0; m = 0;
        exp_ops.delete(); exp_rd.delete();
        exp_k = 0; exp_n = 0;
        while (r > 0 && c > 0) begin
            exp_rd.push_back(r * 1024 + c);
            d = mem[r][c];
            v = int'(d[1:0]);
            if (m == 2)      op = 1;
            else if (m == 1) op = 2;
            else             op = (v == 1) ? 1 : (v == 2) ? 2 : 0;
            if (op == 0) begin r--; c--; m = 0; end
            else if (op == 1) begin r--; m = d[3] ? 0 : 2; end
            else begin c--; m = d[2] ? 0 : 1; end
            exp_ops.push_back(op);
            exp_k++;
        end
        while (r > 0) begin exp_ops.push_back(1); r--; exp_n++; end
        while (c > 0) begin exp_ops.push_back(2); c--; exp_n++; end
    endtask

    // mode 0: ready always high; 1: random ready and stray starts; 2: 5-cycle stall on first op
    task automatic run(input int r, input int c, input int mode, input string name);
        int j, done_j, stall_left, stalls;
        bit busy_ok, stall_ok, pend, valid_at_done;
        logic [1:0] pop;
        model(r, c);
        got_ops.delete(); got_rd.delete();
        @(negedge i_clk);
        i_start = 1'b1; i_row = ROW_W'(r); i_col = COL_W'(c); i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        j = 1; done_j = -1; busy_ok = 1; stall_ok = 1; pend = 0; pop = '0;
        stall_left = 5; stalls = 0; valid_at_done = 0;
        while (j <= 400) begin
            if (j == 1) check({name, "_len_clr"}, 32'(o_len), 0);
            if (!o_busy) busy_ok = 0;
            if (pend && !(o_valid && o_op == pop)) stall_ok = 0;
            if (o_mem_en) got_rd.push_back(int'(o_mem_row) * 1024 + int'(o_mem_col));
            if (o_done) begin
                done_j = j; valid_at_done = o_valid;
                break;
            end
            case (mode)
                1: begin
                    i_ready = 1'($urandom_range(0, 1));
                    i_start = 1'($urandom_range(0, 1));
                    i_row = ROW_W'($urandom_range(0, 9));
                    i_col = COL_W'($urandom_range(0, 9));
                end
                2: begin
                    if (o_valid && stall_left > 0) begin
                        i_ready = 1'b0; stall_left--; stalls++;
                    end else i_ready = 1'b1;
                end
                default: i_ready = 1'b1;
            endcase
            if (o_valid && i_ready) got_ops.push_back(int'(o_op));
            pend = o_valid && !i_ready;
            pop = o_op;
            @(negedge i_clk);
            j++;
        end
        i_start = 1'b0; i_ready = 1'b1;
        check({name, "_done_seen"}, 32'(done_j > 0), 1);
        check({name, "_busy"}, 32'(busy_ok), 1);
        check({name, "_stall_hold"}, 32'(stall_ok), 1);
        check({name, "_valid_at_done"}, 32'(valid_at_done), 0);
        check({name, "_len"}, 32'(o_len), 32'(exp_ops.size()));
        check({name, "_nops"}, 32'(got_ops.size()), 32'(exp_ops.size()));
        for (int i = 0; i < exp_ops.size() && i < got_ops.size(); i++)
            check($sformatf("%s_op%0d", name, i), 32'(got_ops[i]), 32'(exp_ops[i]));
        check({name, "_nreads"}, 32'(got_rd.size()), 32'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
            check($sformatf("%s_rd%0d", name, i), 32'(got_rd[i]), 32'(exp_rd[i]));
        if (mode == 0) check({name, "_done_cyc"}, 32'(done_j), 32'(3 * exp_k + exp_n + 1));
        if (mode == 2) check({name, "_stalls"}, 32'(stalls), 5);
        @(negedge i_clk);
        check({name, "_idle"}, {30'd0, o_busy, o_done}, 0);
    endtask

    initial begin
        bit quiet;
        i_rst_n = 1'b0; i_start = 1'b0; i_row = '0; i_col = '0; i_ready = 1'b1;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) mem[r][c] = 4'h0;
        repeat (3) @(negedge i_clk);
        check("rst_ctl", {28'd0, o_mem_en, o_valid, o_busy, o_done}, 0);
        check("rst_data", {10'd0, o_op, o_mem_row, o_mem_col}, 0);
        check("rst_len", 32'(o_len), 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        run(3, 3, 0, "diag");

        mem[2][4] = 4'b0010; mem[2][3] = 4'b0101; mem[2][2] = 4'b0000; mem[1][1] = 4'b0000;
        run(2, 4, 0, "gap");
        run(2, 4, 2, "gap_stall");

        run(2, 0, 0, "tail_row");
        run(0, 3, 0, "tail_col");
        run(0, 0, 0, "origin");

        mem[3][1] = 4'b0001; mem[2][1] = 4'b1010; mem[1][1] = 4'b0011;
        run(3, 1, 0, "del");

        for (int t = 0; t < 12; t++) begin
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++) mem[r][c] = 4'($urandom);
            run($urandom_range(0, 9), $urandom_range(0, 9), (t % 3 == 2) ? 2 : t % 2,
                $sformatf("rnd%0d", t));
        end

        // Asynchronous reset in the middle of a TAIL run
        @(negedge i_clk);
        i_start = 1'b1; i_row = 10'd0; i_col = 10'd5; i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_ctl", {28'd0, o_mem_en, o_valid, o_busy, o_done}, 0);
        check("arst_data", {10'd0, o_op, o_mem_row, o_mem_col}, 0);
        check("arst_len", 32'(o_len), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        quiet = 1;
        repeat (3) begin
            @(negedge i_clk);
            if (o_done || o_valid) quiet = 0;
        end
        check("arst_no_done", 32'(quiet), 1);
        mem[1][1] = 4'b0000;
        run(1, 1, 0, "restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
